led_pattern_engine: RTL and testbench

Parametrised LED pattern generator for the board LED bank, replacing the fixed single-LED runner. It drives an N-bit LED vector with one of four step patterns (rotate left, rotate right, bounce, fill/drain) at a programmable step rate. It supports pause and single-step, and emits a per-step strobe and a pattern-complete strobe for the UART status path. It sits directly between the board clock/reset and the LED pins.

---
 rtl/led_pattern_engine.sv | 152 +++++++++++++++
 tb/tb_led_pattern_engine.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/led_pattern_engine.sv
// LED bank pattern generator: rotate left/right, bounce, fill/drain at a programmable step rate.
// Latency: led, step_pulse and wrap register on the edge that takes the step.
// Backpressure: none; pause freezes the prescaler and step_req then advances one step at a time.
module led_pattern_engine #(
    parameter int N_LED    = 8,
    parameter int TICK_DIV = 2_500_000,
    parameter int DIV_W    = 26
) (
    input  logic             ext_clk_25m,
    input  logic             ext_rst,
    input  logic [1:0]       mode,
    input  logic [1:0]       speed,
    input  logic             pause,
    input  logic             step_req,
    output logic [N_LED-1:0] led,
    output logic             step_pulse,
    output logic             wrap
);

    localparam logic [1:0] MODE_ROL    = 2'b00;
    localparam logic [1:0] MODE_ROR    = 2'b01;
    localparam logic [1:0] MODE_BOUNCE = 2'b10;
    localparam logic [1:0] MODE_FILL   = 2'b11;

    localparam logic [N_LED-1:0] LED_ONE = {{(N_LED-1){1'b0}}, 1'b1};
    localparam logic [DIV_W-1:0] TICK    = DIV_W'(TICK_DIV);

    typedef enum logic {DIR_UP, DIR_DOWN} dir_t;
    typedef enum logic {PH_FILL, PH_DRAIN} phase_t;

    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [N_LED-1:0] led_q, led_d;
    dir_t             dir_q, dir_d;
    phase_t           phase_q, phase_d;
    logic [1:0]       mode_q;
    logic             pulse_q, pulse_d;
    logic             wrap_q, wrap_d;

    logic [DIV_W-1:0] period;
    logic [DIV_W-1:0] period_m1;
    logic             auto_step;
    logic             man_step;
    logic             step;
    logic             reload;

    logic [N_LED-1:0] pat_led;
    dir_t             pat_dir;
    phase_t           pat_phase;
    logic             pat_wrap;

    // >= rather than == so that lowering speed mid-count still fires promptly
    assign period    = TICK << speed;
    assign period_m1 = period - DIV_W'(1);
    assign auto_step = !pause && (cnt_q >= period_m1);
    assign man_step  = pause && step_req;
    assign step      = auto_step || man_step;
    assign reload    = (mode != mode_q);

    // State register
    always_ff @(posedge ext_clk_25m or posedge ext_rst) begin
        if (ext_rst) begin
            cnt_q   <= '0;
            led_q   <= LED_ONE;
            dir_q   <= DIR_UP;
            phase_q <= PH_FILL;
            mode_q  <= MODE_ROL;
            pulse_q <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            led_q   <= led_d;
            dir_q   <= dir_d;
            phase_q <= phase_d;
            mode_q  <= mode;
            pulse_q <= pulse_d;
            wrap_q  <= wrap_d;
        end
    end

    // Candidate next pattern, applied only when a step is taken
    always_comb begin
        pat_led   = led_q;
        pat_dir   = dir_q;
        pat_phase = phase_q;
        pat_wrap  = 1'b0;
        case (mode_q)
            MODE_ROL: begin
                pat_led  = {led_q[N_LED-2:0], led_q[N_LED-1]};
                pat_wrap = (pat_led == LED_ONE);
            end
            MODE_ROR: begin
                pat_led  = {led_q[0], led_q[N_LED-1:1]};
                pat_wrap = (pat_led == LED_ONE);
            end
            MODE_BOUNCE: begin
                if (dir_q == DIR_UP) begin
                    pat_led = led_q << 1;
                    if (pat_led[N_LED-1]) pat_dir = DIR_DOWN;
                end else begin
                    pat_led = led_q >> 1;
                    if (pat_led[0]) begin
                        pat_dir  = DIR_UP;
                        pat_wrap = 1'b1;
                    end
                end
            end
            MODE_FILL: begin
                if (phase_q == PH_FILL) begin
                    pat_led  = {led_q[N_LED-2:0], 1'b1};
                    pat_wrap = (led_q == '0);
                    if (&pat_led) pat_phase = PH_DRAIN;
                end else begin
                    pat_led = {led_q[N_LED-2:0], 1'b0};
                    if (pat_led == '0) pat_phase = PH_FILL;
                end
            end
        endcase
    end

    // Next-state: a mode reload overrides any coincident step
    always_comb begin
        cnt_d   = cnt_q;
        led_d   = led_q;
        dir_d   = dir_q;
        phase_d = phase_q;
        pulse_d = 1'b0;
        wrap_d  = 1'b0;
        if (reload) begin
            cnt_d   = '0;
            led_d   = LED_ONE;
            dir_d   = DIR_UP;
            phase_d = PH_FILL;
        end else begin
            if (!pause) cnt_d = auto_step ? '0 : cnt_q + DIV_W'(1);
            if (step) begin
                led_d   = pat_led;
                dir_d   = pat_dir;
                phase_d = pat_phase;
                pulse_d = 1'b1;
                wrap_d  = pat_wrap;
            end
        end
    end

    // Outputs
    always_comb begin
        led        = led_q;
        step_pulse = pulse_q;
        wrap       = wrap_q;
    end

endmodule

// File: tb/tb_led_pattern_engine.sv
// Directed bench for led_pattern_engine (N_LED=8, TICK_DIV=4): patterns, pause/step, reload, reset.
module tb_led_pattern_engine;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] mode;
    logic [1:0] speed;
    logic       pause;
    logic       step_req;
    logic [7:0] led;
    logic       step_pulse;
    logic       wrap;

    int checks = 0;
    int errors = 0;

    logic [7:0] seq_rol [8]  = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01};
    logic [7:0] seq_ror [8]  = '{8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01};
    logic [7:0] seq_bnc [14] = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
                                 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01};
    logic [7:0] seq_fil [16] = '{8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF, 8'hFE,
                                 8'hFC, 8'hF8, 8'hF0, 8'hE0, 8'hC0, 8'h80, 8'h00, 8'h01};

    led_pattern_engine #(.N_LED(8), .TICK_DIV(4), .DIV_W(8)) dut (
        .ext_clk_25m(clk),
        .ext_rst    (rst),
        .mode       (mode),
        .speed      (speed),
        .pause      (pause),
        .step_req   (step_req),
        .led        (led),
        .step_pulse (step_pulse),
        .wrap       (wrap)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expects no step for per-1 edges, then a step on the per-th edge
    task automatic run_step(input string tag, input logic [7:0] exp_led,
                            input logic exp_wrap, input int per);
        repeat (per - 1) begin
            tick();
            chk({tag, " idle_pulse"}, {31'd0, step_pulse}, 32'd0);
        end
        tick();
        chk({tag, " led"},   {24'd0, led},        {24'd0, exp_led});
        chk({tag, " pulse"}, {31'd0, step_pulse}, 32'd1);
        chk({tag, " wrap"},  {31'd0, wrap},       {31'd0, exp_wrap});
    endtask

    task automatic chk_reload(input string tag);
        tick();
        chk({tag, " reload_led"},   {24'd0, led},        32'd1);
        chk({tag, " reload_pulse"}, {31'd0, step_pulse}, 32'd0);
        chk({tag, " reload_wrap"},  {31'd0, wrap},       32'd0);
    endtask

    initial begin
        rst = 1'b1; mode = 2'b00; speed = 2'b00; pause = 1'b0; step_req = 1'b0;
        repeat (3) tick();
        chk("rst led",   {24'd0, led},        32'd1);
        chk("rst pulse", {31'd0, step_pulse}, 32'd0);
        chk("rst wrap",  {31'd0, wrap},       32'd0);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) run_step("rol", seq_rol[i], i == 7, 4);

        mode = 2'b01;
        chk_reload("ror");
        for (int i = 0; i < 8; i++) run_step("ror", seq_ror[i], i == 7, 4);

        mode = 2'b10;
        chk_reload("bnc");
        for (int i = 0; i < 14; i++) run_step("bnc", seq_bnc[i], i == 13, 4);

        mode = 2'b11; speed = 2'd2;
        chk_reload("fil");
        for (int i = 0; i < 16; i++) run_step("fil", seq_fil[i], i == 15, 16);

        // Pause with cnt=1, two manual steps, then resume from the frozen count
        mode = 2'b00; speed = 2'd0;
        chk_reload("pse");
        run_step("pse a", 8'h02, 1'b0, 4);
        run_step("pse b", 8'h04, 1'b0, 4);
        tick();
        pause = 1'b1;
        repeat (50) begin
            tick();
            chk("pse hold_pulse", {31'd0, step_pulse}, 32'd0);
        end
        chk("pse hold_led", {24'd0, led}, 32'h04);
        step_req = 1'b1;
        tick();
        step_req = 1'b0;
        chk("man1 led",   {24'd0, led},        32'h08);
        chk("man1 pulse", {31'd0, step_pulse}, 32'd1);
        tick();
        chk("man1 pulse_end", {31'd0, step_pulse}, 32'd0);
        step_req = 1'b1;
        tick();
        step_req = 1'b0;
        chk("man2 led", {24'd0, led}, 32'h10);
        pause = 1'b0;
        run_step("resume", 8'h20, 1'b0, 3);

        // step_req while running is ignored
        step_req = 1'b1;
        tick();
        step_req = 1'b0;
        chk("ign led",   {24'd0, led},        32'h20);
        chk("ign pulse", {31'd0, step_pulse}, 32'd0);
        run_step("ign next", 8'h40, 1'b0, 3);

        // Mode change coincident with cnt=P-1: reload wins
        repeat (3) tick();
        mode = 2'b01;
        chk_reload("mchg");
        run_step("mchg next", 8'h80, 1'b0, 4);

        // Speed drop mid-count fires on the next edge
        speed = 2'd1;
        repeat (5) begin
            tick();
            chk("spd idle_pulse", {31'd0, step_pulse}, 32'd0);
        end
        speed = 2'd0;
        run_step("spd", 8'h40, 1'b0, 1);

        // Asynchronous reset while step_pulse is high
        rst = 1'b1;
        #1;
        chk("arst led",   {24'd0, led},        32'd1);
        chk("arst pulse", {31'd0, step_pulse}, 32'd0);
        chk("arst wrap",  {31'd0, wrap},       32'd0);
        mode = 2'b00;
        tick();
        tick();
        rst = 1'b0;
        run_step("post_rst", 8'h02, 1'b0, 4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
